// File: rtl/sisc_pkg.sv
// sisc_pkg -- shared types and defaults for the data-memory arbiter.
// Rev 1.0
`default_nettype none

package sisc_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_CPU  = 2'b01,
    ARB_LDR  = 2'b10
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr -- 4-bit saturating counter of contested processor wins.
// Rev 1.0
`default_nettype none

module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic CLK,
  input  logic RST_F,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [3:0] MAX_VAL = 4'(STARVE_MAX);

  logic [3:0] count;

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      count <= 4'd0;
    end else if (clr) begin
      count <= 4'd0;
    end else if (inc && (count != MAX_VAL)) begin
      count <= count + 4'd1;
    end
  end

  assign sat = (count == MAX_VAL);

endmodule

`default_nettype wire

// File: rtl/dm_arbiter.sv
// dm_arbiter -- shares the single-port data memory between processor and loader.
// Rev 1.0
`default_nettype none

module dm_arbiter
  import sisc_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic          CLK,
  input  logic          RST_F,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_gnt,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_rvalid,
  input  logic          ldr_lock,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  output logic          dm_we,
  input  logic [DW-1:0] dm_rdata
);

  arb_state_t    state;
  arb_state_t    next_state;
  logic          starve_inc;
  logic          starve_clr;
  logic          starve_sat;
  logic [DW-1:0] rd_q;

  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .CLK   (CLK),
    .RST_F (RST_F),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .sat   (starve_sat)
  );

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      state <= ARB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = ARB_IDLE;
    if ((state == ARB_LDR) && ldr_lock && ldr_req) begin
      next_state = ARB_LDR;
    end else if (cpu_req && ldr_req) begin
      next_state = starve_sat ? ARB_LDR : ARB_CPU;
    end else if (cpu_req) begin
      next_state = ARB_CPU;
    end else if (ldr_req) begin
      next_state = ARB_LDR;
    end
  end

  always_comb begin
    starve_inc = (next_state == ARB_CPU) && ldr_req;
    starve_clr = (next_state == ARB_LDR) || !ldr_req;
  end

  // The owner's command is captured at the granting edge, so requesters may
  // present their next access while the current one is on the memory bus.
  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      dm_addr  <= '0;
      dm_wdata <= '0;
      dm_we    <= 1'b0;
    end else begin
      case (next_state)
        ARB_CPU: begin
          dm_addr  <= cpu_addr;
          dm_wdata <= cpu_wdata;
          dm_we    <= cpu_we;
        end
        ARB_LDR: begin
          dm_addr  <= ldr_addr;
          dm_wdata <= ldr_wdata;
          dm_we    <= ldr_we;
        end
        default: begin
          dm_addr  <= '0;
          dm_wdata <= '0;
          dm_we    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      rd_q       <= '0;
      cpu_rvalid <= 1'b0;
      ldr_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= (state == ARB_CPU) && !dm_we;
      ldr_rvalid <= (state == ARB_LDR) && !dm_we;
      if ((state != ARB_IDLE) && !dm_we) begin
        rd_q <= dm_rdata;
      end
    end
  end

  assign cpu_gnt   = (state == ARB_CPU);
  assign ldr_gnt   = (state == ARB_LDR);
  assign cpu_rdata = rd_q;
  assign ldr_rdata = rd_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter -- directed scoreboard bench for dm_arbiter.
// Rev 1.0
`default_nettype none

module tb_dm_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;

  typedef struct packed {
    logic [1:0]    own;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } gnt_exp_t;

  typedef struct packed {
    logic [1:0]    own;
    logic [DW-1:0] data;
  } rd_exp_t;

  logic          CLK;
  logic          RST_F;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          ldr_req, ldr_we, ldr_gnt, ldr_rvalid, ldr_lock;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata, ldr_rdata;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          dm_we;

  logic [DW-1:0] mem [0:65535];
  gnt_exp_t      gq[$];
  rd_exp_t       rq[$];
  int            total;
  int            passed;

  dm_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
    .CLK        (CLK),
    .RST_F      (RST_F),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .ldr_gnt    (ldr_gnt),
    .ldr_rdata  (ldr_rdata),
    .ldr_rvalid (ldr_rvalid),
    .ldr_lock   (ldr_lock),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_we      (dm_we),
    .dm_rdata   (dm_rdata)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Memory with combinational read, synchronous write.
  assign dm_rdata = mem[dm_addr];
  always @(posedge CLK) begin
    if (dm_we) mem[dm_addr] <= dm_wdata;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
    else passed++;
  endtask

  always @(negedge CLK) begin
    gnt_exp_t g;
    rd_exp_t  r;
    chk("gnt_onehot", 64'(cpu_gnt & ldr_gnt), 64'd0);
    if (cpu_gnt || ldr_gnt) begin
      if (gq.size() == 0) begin
        chk("unexpected_gnt", 64'({cpu_gnt, ldr_gnt}), 64'd0);
      end else begin
        g = gq.pop_front();
        chk("gnt_access", 64'({ldr_gnt, cpu_gnt, dm_addr, dm_we, dm_wdata}), 64'(g));
      end
    end else begin
      chk("idle_bus", 64'({dm_addr, dm_we, dm_wdata}), 64'd0);
    end
    chk("rvalid_onehot", 64'(cpu_rvalid & ldr_rvalid), 64'd0);
    if (cpu_rvalid || ldr_rvalid) begin
      if (rq.size() == 0) begin
        chk("unexpected_rvalid", 64'({cpu_rvalid, ldr_rvalid}), 64'd0);
      end else begin
        r = rq.pop_front();
        chk("rdata", 64'({ldr_rvalid, cpu_rvalid, cpu_rdata}), 64'(r));
        chk("rdata_shared", 64'(ldr_rdata), 64'(r.data));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_ldr(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ldr_req = req; ldr_we = we; ldr_addr = a; ldr_wdata = d;
  endtask

  initial begin
    total = 0;
    passed = 0;
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    mem[1] = 32'h11;
    mem[2] = 32'h22;
    mem[3] = 32'h33;
    RST_F = 1'b0;
    ldr_lock = 1'b0;
    set_cpu(0, 0, 0, 0);
    set_ldr(0, 0, 0, 0);
    step(2);
    chk("reset_gnt", 64'({cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid}), 64'd0);
    chk("reset_bus", 64'({dm_addr, dm_we, dm_wdata}), 64'd0);
    chk("reset_rdata", 64'({cpu_rdata, ldr_rdata}), 64'd0);
    RST_F = 1'b1;
    step(1);

    // Processor write then read-back.
    set_cpu(1, 1, 16'h0010, 32'hDEADBEEF);
    gq.push_back('{2'b01, 16'h0010, 1'b1, 32'hDEADBEEF});
    step(1);
    cpu_req = 1'b0;
    step(2);
    set_cpu(1, 0, 16'h0010, 32'h0);
    gq.push_back('{2'b01, 16'h0010, 1'b0, 32'h0});
    rq.push_back('{2'b01, 32'hDEADBEEF});
    step(1);
    cpu_req = 1'b0;
    step(3);

    // Sustained contention: four processor wins then one forced loader grant.
    set_cpu(1, 1, 16'h0020, 32'hAAAA0001);
    set_ldr(1, 1, 16'h0030, 32'hBBBB0002);
    for (int i = 0; i < 10; i++) begin
      if ((i % 5) == 4) gq.push_back('{2'b10, 16'h0030, 1'b1, 32'hBBBB0002});
      else              gq.push_back('{2'b01, 16'h0020, 1'b1, 32'hAAAA0001});
    end
    step(10);
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    step(3);

    // Loader lock holds off the processor for six loader reads.
    set_ldr(1, 0, 16'h0010, 32'h0);
    ldr_lock = 1'b1;
    for (int i = 0; i < 6; i++) begin
      gq.push_back('{2'b10, 16'h0010, 1'b0, 32'h0});
      rq.push_back('{2'b10, 32'hDEADBEEF});
    end
    gq.push_back('{2'b01, 16'h0040, 1'b1, 32'h00000055});
    step(1);
    set_cpu(1, 1, 16'h0040, 32'h00000055);
    step(5);
    ldr_req = 1'b0;
    ldr_lock = 1'b0;
    step(1);
    cpu_req = 1'b0;
    step(3);

    // Back-to-back processor reads.
    for (int i = 1; i <= 3; i++) begin
      set_cpu(1, 0, 16'(i), 32'h0);
      gq.push_back('{2'b01, 16'(i), 1'b0, 32'h0});
      rq.push_back('{2'b01, 32'(i * 32'h11)});
      step(1);
    end
    cpu_req = 1'b0;
    step(3);

    // Idle stretch.
    step(5);

    // Reset in the middle of a loader write.
    set_ldr(1, 1, 16'h0050, 32'h00000077);
    gq.push_back('{2'b10, 16'h0050, 1'b1, 32'h00000077});
    step(1);
    ldr_req = 1'b0;
    #5;
    RST_F = 1'b0;
    #1;
    chk("rst_mid_gnt", 64'({cpu_gnt, ldr_gnt}), 64'd0);
    chk("rst_mid_we", 64'({dm_we, dm_addr}), 64'd0);
    step(2);
    RST_F = 1'b1;
    step(2);
    set_ldr(1, 0, 16'h0050, 32'h0);
    gq.push_back('{2'b10, 16'h0050, 1'b0, 32'h0});
    rq.push_back('{2'b10, 32'h0});
    step(1);
    ldr_req = 1'b0;
    step(4);

    chk("gnt_queue_drained", 64'(gq.size()), 64'd0);
    chk("rd_queue_drained", 64'(rq.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
